// File: rtl/neuron_pkg.sv
// Shared constants, types and helpers for the digital LIF neuron datapath.
// All voltages and currents are signed Q10.10 in DW bits (1.0 = 1024).
package neuron_pkg;

  localparam int DW   = 21;
  localparam int FRAC = 10;

  // Firing threshold, 15.0 in Q10.10; the spike/reset selector uses the same value.
  localparam logic signed [DW-1:0] TH_RAW = 21'sd15360;
  localparam logic signed [DW-1:0] VMAX   = 21'sh0FFFFF;
  localparam logic signed [DW-1:0] VMIN   = 21'sh100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Clamp a DW+2-bit signed sum into the DW-bit range. The value fits when the
  // top three bits are all equal (pure sign extension of bit DW-1).
  function automatic logic signed [DW-1:0] sat_to_dw(input logic signed [DW+1:0] s);
    logic signed [DW-1:0] r;
    if ((s[DW+1:DW-1] == 3'b000) || (s[DW+1:DW-1] == 3'b111)) begin
      r = s[DW-1:0];
    end else if (s[DW+1]) begin
      r = VMIN;
    end else begin
      r = VMAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add_q10.sv
// Combinational saturating adder for Q10.10 operands: adds at DW+2 bits and
// clamps the result back to DW bits. Also used by synapse accumulation stages.
module sat_add_q10
  import neuron_pkg::*;
(
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] y_o
);

  logic signed [DW+1:0] sum_s;

  // Sign-extend both operands, add without overflow, then clamp.
  always_comb begin
    sum_s = {{2{a_i[DW-1]}}, a_i} + {{2{b_i[DW-1]}}, b_i};
    y_o   = sat_to_dw(sum_s);
  end

endmodule

// File: rtl/lif_membrane_integrator.sv
// Membrane integrator of the LIF neuron: once per accepted timestep applies
// leak to the selector's post-reset voltage, adds synaptic current (unless the
// neuron fires or is refractory), saturates and registers the new potential.
module lif_membrane_integrator
  import neuron_pkg::*;
#(
  parameter int                   LEAK_SHIFT   = 4,
  parameter int                   REFRAC_STEPS = 2,
  parameter logic signed [DW-1:0] V_INIT       = 21'sd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] i_syn,
  input  logic signed [DW-1:0] v_sel,
  output logic signed [DW-1:0] v_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 spike,
  output logic                 refrac_busy
);

  localparam int RCW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  state_e                state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  spike_q;
  logic                  refrac_busy_q;
  logic [RCW-1:0]        refrac_q;
  logic [RCW-1:0]        refrac_d;
  logic signed [DW-1:0]  v_q;
  logic signed [DW-1:0]  v_d;
  logic signed [DW-1:0]  i_syn_q;
  logic signed [DW-1:0]  v_sel_q;

  logic                  fire_s;
  logic signed [DW-1:0]  leaked_s;
  logic signed [DW-1:0]  add_s;

  // Timestep datapath: fire decision on the current potential, leak on the
  // latched selector output, input gating and refractory counter update.
  always_comb begin
    fire_s   = (v_q[DW-1] == 1'b0) && (v_q >= TH_RAW);
    // v - (v >>> k) shrinks |v|, so it never overflows DW bits.
    leaked_s = v_sel_q - (v_sel_q >>> LEAK_SHIFT);
    if (fire_s || (refrac_q != {RCW{1'b0}})) begin
      add_s = {DW{1'b0}};
    end else begin
      add_s = i_syn_q;
    end
    if (fire_s) begin
      refrac_d = RCW'(REFRAC_STEPS);
    end else if (refrac_q != {RCW{1'b0}}) begin
      refrac_d = refrac_q - RCW'(1);
    end else begin
      refrac_d = refrac_q;
    end
  end

  sat_add_q10 u_sat_add (
    .a_i (leaked_s),
    .b_i (add_s),
    .y_o (v_d)
  );

  // Control FSM with registered handshake outputs and membrane state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      spike_q       <= 1'b0;
      refrac_busy_q <= 1'b0;
      refrac_q      <= {RCW{1'b0}};
      v_q           <= V_INIT;
      i_syn_q       <= {DW{1'b0}};
      v_sel_q       <= {DW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_ready_q && in_valid) begin
            i_syn_q    <= i_syn;
            v_sel_q    <= v_sel;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_CALC: begin
          v_q           <= v_d;
          spike_q       <= fire_s;
          refrac_q      <= refrac_d;
          refrac_busy_q <= (refrac_d != {RCW{1'b0}});
          out_valid_q   <= 1'b1;
          state_q       <= S_OUT;
        end
        S_OUT: begin
          // Result is held until consumed; a new sample is only accepted
          // from S_IDLE, never in the same cycle as the hand-off.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign spike       = spike_q;
  assign refrac_busy = refrac_busy_q;
  assign v_out       = v_q;

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Self-checking bench for lif_membrane_integrator: directed vector table,
// hand-written reset/backpressure sequences and randomized steps checked
// against an arithmetic reference model of one neuron timestep.
module tb_lif_membrane_integrator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [20:0] i_syn;
  logic signed [20:0] v_sel;
  logic signed [20:0] v_out;
  logic               out_valid;
  logic               out_ready;
  logic               spike;
  logic               refrac_busy;

  // v_sel source: 0 = loopback of v_out, 1 = selector model (reset to 0 at
  // threshold), 2 = forced value.
  int                 sel_mode = 0;
  logic signed [20:0] v_sel_force = 21'sd0;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;

  // Reference model state.
  int m_v   = 0;
  int m_ref = 0;
  int m_spk = 0;

  always #5 clk = ~clk;

  assign v_sel = (sel_mode == 0) ? v_out :
                 (sel_mode == 1) ? ((v_out >= 21'sd15360) ? 21'sd0 : v_out) :
                 v_sel_force;

  lif_membrane_integrator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .i_syn       (i_syn),
    .v_sel       (v_sel),
    .v_out       (v_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .spike       (spike),
    .refrac_busy (refrac_busy)
  );

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int floor_div16(input int x);
    int q;
    q = x / 16;
    if ((x < 0) && ((x % 16) != 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_vsel(input int mode, input int force_v);
    if (mode == 0) return m_v;
    if (mode == 1) return (m_v >= 15360) ? 0 : m_v;
    return force_v;
  endfunction

  task automatic model_step(input int vs, input int is);
    int fire, sum;
    fire = (m_v >= 15360);
    sum  = vs - floor_div16(vs);
    if (!fire && (m_ref == 0)) sum = sum + is;
    if (sum > 1048575) sum = 1048575;
    if (sum < -1048576) sum = -1048576;
    m_v   = sum;
    m_spk = fire;
    if (fire) m_ref = 2;
    else if (m_ref > 0) m_ref = m_ref - 1;
  endtask

  task automatic model_reset();
    m_v = 0; m_ref = 0; m_spk = 0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while ((in_ready !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("in_ready_timeout", int'(in_ready), 1);
  endtask

  // One full timestep: accept, check 2-cycle latency, update model, report DUT outputs.
  task automatic run_step(input int mode, input int vsf, input int isyn, input int stall,
                          output int gv, output int gs, output int gb);
    int vs;
    wait_ready();
    sel_mode    = mode;
    v_sel_force = 21'(vsf);
    i_syn       = 21'(isyn);
    in_valid    = 1'b1;
    out_ready   = (stall == 0);
    vs = model_vsel(mode, vsf);
    @(negedge clk);
    in_valid = 1'b0;
    chk("calc_out_valid_low", int'(out_valid), 0);
    @(negedge clk);
    chk("latency_out_valid", int'(out_valid), 1);
    model_step(vs, isyn);
    gv = v_out; gs = spike; gb = refrac_busy;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_v_out", int'(v_out), m_v);
    end
    out_ready = 1'b1;
  endtask

  typedef struct {
    int mode; int vsf; int isyn; int ev; int es; int eb;
  } vec_t;

  vec_t tbl [0:12];

  initial begin
    int gv, gs, gb, snap, r, mode, vsf, is, st;
    logic signed [20:0] r21;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gv, gs, gb, snap, mode, vsf, is, st;
    logic signed [20:0] r21;

    tbl[0]  = '{0, 0, 1024, 1024, 0, 0};
    tbl[1]  = '{0, 0, 1024, 1984, 0, 0};
    tbl[2]  = '{2, 0, 15360, 15360, 0, 0};
    tbl[3]  = '{1, 0, 1024, 0, 1, 1};
    tbl[4]  = '{1, 0, 1024, 0, 0, 1};
    tbl[5]  = '{1, 0, 1024, 0, 0, 0};
    tbl[6]  = '{1, 0, 1024, 1024, 0, 0};
    tbl[7]  = '{2, 15359, 1048575, 1048575, 0, 0};
    tbl[8]  = '{2, 0, 0, 0, 1, 1};
    tbl[9]  = '{2, 0, 0, 0, 0, 1};
    tbl[10] = '{2, 0, 0, 0, 0, 0};
    tbl[11] = '{2, -1048576, -1048576, -1048576, 0, 0};
    tbl[12] = '{0, 0, 0, -983040, 0, 0};

    // Power-on reset.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; i_syn = 21'sd0;
    repeat (3) @(negedge clk);
    chk("rst_v_out", int'(v_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_refrac_busy", int'(refrac_busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", int'(in_ready), 1);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run_step(tbl[i].mode, tbl[i].vsf, tbl[i].isyn, 0, gv, gs, gb);
      chk($sformatf("tbl%0d_v_out", i), gv, tbl[i].ev);
      chk($sformatf("tbl%0d_spike", i), gs, tbl[i].es);
      chk($sformatf("tbl%0d_refrac_busy", i), gb, tbl[i].eb);
    end

    // Reset held 3 cycles while in S_CALC.
    wait_ready();
    sel_mode = 0; i_syn = 21'sd1024; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("calc_rst_v_out", int'(v_out), 0);
    chk("calc_rst_out_valid", int'(out_valid), 0);
    chk("calc_rst_spike", int'(spike), 0);
    chk("calc_rst_refrac_busy", int'(refrac_busy), 0);
    chk("calc_rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("calc_rst_in_ready_release", int'(in_ready), 1);
    chk("calc_rst_no_result", int'(out_valid), 0);
    model_reset();

    // Backpressure: result held for 5 cycles while in_valid stays high.
    wait_ready();
    sel_mode = 0; i_syn = 21'sd2048; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    i_syn = 21'sd4096;
    @(negedge clk);
    chk("bp_out_valid", int'(out_valid), 1);
    model_step(0, 2048);
    chk("bp_v_out", int'(v_out), m_v);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_out_valid", int'(out_valid), 1);
      chk("bp_hold_v_out", int'(v_out), m_v);
      chk("bp_hold_spike", int'(spike), m_spk);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    snap = acc_cnt;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_single_accept", acc_cnt - snap, 1);
    @(negedge clk);
    chk("bp_second_out_valid", int'(out_valid), 1);
    model_step(m_v, 4096);
    chk("bp_second_v_out", int'(v_out), m_v);

    // Reset while a fired result waits in S_OUT.
    run_step(2, 0, 15360, 0, gv, gs, gb);
    chk("pre_fire_v_out", gv, 15360);
    wait_ready();
    sel_mode = 1; i_syn = 21'sd1024; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("out_rst_pre_spike", int'(spike), 1);
    chk("out_rst_pre_busy", int'(refrac_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("out_rst_spike", int'(spike), 0);
    chk("out_rst_v_out", int'(v_out), 0);
    chk("out_rst_busy", int'(refrac_busy), 0);
    chk("out_rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    model_reset();
    run_step(0, 0, 1024, 0, gv, gs, gb);
    chk("post_rst_v_out", gv, 1024);
    chk("post_rst_spike", gs, 0);
    chk("post_rst_busy", gb, 0);

    // Randomized steps against the reference model.
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 2);
      r21  = 21'($urandom);
      vsf  = ($urandom_range(0, 1) == 0) ? int'(r21) : int'($urandom_range(0, 20000));
      case ($urandom_range(0, 3))
        0: begin r21 = 21'($urandom); is = r21; end
        1: is = int'($urandom_range(0, 8192)) - 4096;
        2: is = int'($urandom_range(8000, 16384));
        default: is = 0;
      endcase
      st = $urandom_range(0, 2);
      run_step(mode, vsf, is, st, gv, gs, gb);
      chk("rand_v_out", gv, m_v);
      chk("rand_spike", gs, m_spk);
      chk("rand_refrac_busy", gb, int'(m_ref != 0));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
